// File: rtl/gen_if_pkg.sv
// Shared types and constants for the generate-if datapath and its skid stage.
// The mode constants name the legal values of the transform-select parameter P.
package gen_if_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int GEN_IF_MODE_PASS = 0;
    localparam int GEN_IF_MODE_INC  = 1;

    localparam int GEN_IF_DEF_WIDTH = 8;
    localparam int GEN_IF_DEF_CNT_W = 16;

endpackage

// File: rtl/gen_if_xform.sv
// P-selected data transform (identity or +1 mod 2^WIDTH); combinational, no latency.
// Has no flow control of its own; only the selected datapath is elaborated.
module gen_if_xform
    import gen_if_pkg::*;
#(
    parameter int P     = GEN_IF_MODE_PASS,
    parameter int WIDTH = GEN_IF_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (P == GEN_IF_MODE_PASS) begin : g_pass
            assign dout = din;
        end else if (P == GEN_IF_MODE_INC) begin : g_inc
            assign dout = din + WIDTH'(1);
        end else begin : g_bad_p
            $error("gen_if_xform: P must be 0 (pass) or 1 (increment)");
            assign dout = din;
        end
    endgenerate

endmodule

// File: rtl/gen_if_skid_stage.sv
// Registered valid/ready stage applying the P-selected transform on capture; 1-cycle latency when empty.
// Backpressure via a 2-entry skid so in_ready stays registered at full rate; GEN_IF_SKID_STATS_EN adds beat_cnt.
module gen_if_skid_stage
    import gen_if_pkg::*;
#(
    parameter int P     = GEN_IF_MODE_PASS,
    parameter int WIDTH = GEN_IF_DEF_WIDTH,
    parameter int CNT_W = GEN_IF_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef GEN_IF_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] beat_cnt
`endif
);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("gen_if_skid_stage: WIDTH must be >= 1");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("gen_if_skid_stage: CNT_W must be >= 1");
        end
    endgenerate

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] xf_data;
    logic             in_fire;
    logic             out_fire;

    gen_if_xform #(
        .P     (P),
        .WIDTH (WIDTH)
    ) u_xform (
        .din  (in_data),
        .dout (xf_data)
    );

    // in_ready_q is already low in TWO, so only the output can fire there.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    data_d  = xf_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    data_d = xf_data;
                end else if (in_fire) begin
                    state_d = TWO;
                    skid_d  = xf_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_d = ONE;
                    data_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            data_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

`ifdef GEN_IF_SKID_STATS_EN
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_fire) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_gen_if_skid_stage.sv
// Bench for gen_if_skid_stage: instance 0 runs P=0, instance 1 runs P=1, both WIDTH=8, CNT_W=4.
// Cycle-exact vector table plus a negedge scoreboard/occupancy model watching both instances.
module tb_gen_if_skid_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
`ifdef GEN_IF_SKID_STATS_EN
    logic [3:0] beat_cnt  [2];
    logic [3:0] cnt_m     [2];
`endif

    int         n_chk;
    int         n_fail;
    logic       live;
    int         occ [2];
    logic [7:0] sbq [2][$];

    gen_if_skid_stage #(.P(0), .WIDTH(8), .CNT_W(4)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0])
`ifdef GEN_IF_SKID_STATS_EN
        ,
        .beat_cnt  (beat_cnt[0])
`endif
    );

    gen_if_skid_stage #(.P(1), .WIDTH(8), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1])
`ifdef GEN_IF_SKID_STATS_EN
        ,
        .beat_cnt  (beat_cnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] xf(input int d, input logic [7:0] v);
        return (d == 1) ? v + 8'd1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = 8'h00;
            out_ready[d] = 1'b0;
        end
    endtask

    // live is low for the first cycle after release, when in_ready has not risen yet.
    always @(posedge clk) live = rst_n;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                sbq[d].delete();
                occ[d] = 0;
`ifdef GEN_IF_SKID_STATS_EN
                cnt_m[d] = 4'd0;
`endif
            end else if (live) begin
                chk($sformatf("dut%0d in_ready_vs_occ", d), 32'(in_ready[d]), 32'(occ[d] != 2));
                chk($sformatf("dut%0d out_valid_vs_occ", d), 32'(out_valid[d]), 32'(occ[d] != 0));
`ifdef GEN_IF_SKID_STATS_EN
                chk($sformatf("dut%0d beat_cnt", d), 32'(beat_cnt[d]), 32'(cnt_m[d]));
`endif
                if (in_valid[d] && in_ready[d]) begin
                    sbq[d].push_back(xf(d, in_data[d]));
                    occ[d]++;
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk($sformatf("dut%0d unexpected_beat", d), 32'(out_data[d]), 32'hFFFF_FFFF);
                    end else begin
                        chk($sformatf("dut%0d sb_data", d), 32'(out_data[d]), 32'(sbq[d].pop_front()));
                    end
                    occ[d]--;
`ifdef GEN_IF_SKID_STATS_EN
                    cnt_m[d] = cnt_m[d] + 4'd1;
`endif
                end
            end
        end
    end

    typedef struct {
        int         dut;
        logic       iv;
        logic [7:0] idat;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        string      nm;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int   sent;
        int   cyc;
        logic fired;

        tbl[0]  = '{0, 1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, "p0_beat"};
        tbl[1]  = '{0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, "p0_drain"};
        tbl[2]  = '{1, 1'b1, 8'hFE, 1'b1, 1'b1, 8'hFF, 1'b1, "p1_fe"};
        tbl[3]  = '{1, 1'b1, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, "p1_ff_wrap"};
        tbl[4]  = '{1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "p1_drain"};
        tbl[5]  = '{1, 1'b1, 8'h01, 1'b0, 1'b1, 8'h02, 1'b1, "skid_fill1"};
        tbl[6]  = '{1, 1'b1, 8'h02, 1'b0, 1'b1, 8'h02, 1'b0, "skid_fill2"};
        tbl[7]  = '{1, 1'b1, 8'h10, 1'b0, 1'b1, 8'h02, 1'b0, "skid_hold"};
        tbl[8]  = '{1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h03, 1'b1, "skid_out_only"};
        tbl[9]  = '{1, 1'b1, 8'h10, 1'b1, 1'b1, 8'h11, 1'b1, "skid_both"};
        tbl[10] = '{1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, "skid_empty"};

        n_chk  = 0;
        n_fail = 0;
        live   = 1'b0;
        rst_n  = 1'b0;
        idle_all();
        for (int d = 0; d < 2; d++) occ[d] = 0;

        // Reset values, then in_ready rises on the first edge after release.
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rst_out_valid", d), 32'(out_valid[d]), 32'd0);
            chk($sformatf("dut%0d rst_out_data", d), 32'(out_data[d]), 32'd0);
            chk($sformatf("dut%0d rst_in_ready", d), 32'(in_ready[d]), 32'd0);
`ifdef GEN_IF_SKID_STATS_EN
            chk($sformatf("dut%0d rst_beat_cnt", d), 32'(beat_cnt[d]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d rel_in_ready", d), 32'(in_ready[d]), 32'd1);
        end

        for (int i = 0; i < 11; i++) begin
            idle_all();
            in_valid[tbl[i].dut]  = tbl[i].iv;
            in_data[tbl[i].dut]   = tbl[i].idat;
            out_ready[tbl[i].dut] = tbl[i].ordy;
            tick();
            chk({tbl[i].nm, " out_valid"}, 32'(out_valid[tbl[i].dut]), 32'(tbl[i].ov));
            chk({tbl[i].nm, " out_data"}, 32'(out_data[tbl[i].dut]), 32'(tbl[i].od));
            chk({tbl[i].nm, " in_ready"}, 32'(in_ready[tbl[i].dut]), 32'(tbl[i].ir));
        end
        idle_all();
        tick();

        // Random traffic on the P=0 instance; upstream holds data until accepted.
        sent  = 0;
        cyc   = 0;
        fired = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!in_valid[0] || fired) begin
                in_valid[0] = ($urandom_range(0, 3) != 0);
                in_data[0]  = 8'($urandom);
            end
            out_ready[0] = ($urandom_range(0, 3) != 0);
            fired = in_valid[0] && in_ready[0];
            if (fired) sent++;
            tick();
            cyc++;
        end
        chk("random_beats_sent", 32'(sent), 32'd1000);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        for (int i = 0; i < 200 && sbq[0].size() != 0; i++) tick();
        tick();
        chk("random_drain_empty", 32'(sbq[0].size()), 32'd0);
        chk("random_drain_out_valid", 32'(out_valid[0]), 32'd0);

        // Fill the P=1 instance to TWO, then reset it mid-operation.
        idle_all();
        in_valid[1] = 1'b1;
        in_data[1]  = 8'h01;
        tick();
        in_data[1]  = 8'h02;
        tick();
        chk("two_in_ready", 32'(in_ready[1]), 32'd0);
        idle_all();
        rst_n = 1'b0;
        tick();
        chk("rst_two_out_valid", 32'(out_valid[1]), 32'd0);
        chk("rst_two_out_data", 32'(out_data[1]), 32'd0);
        chk("rst_two_in_ready", 32'(in_ready[1]), 32'd0);
        rst_n = 1'b1;
        out_ready[1] = 1'b1;
        tick();
        chk("rel_two_in_ready", 32'(in_ready[1]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_beat", 32'(out_valid[1]), 32'd0);
            tick();
        end

`ifdef GEN_IF_SKID_STATS_EN
        // 17 output fires on a 4-bit counter wrap it to 1.
        idle_all();
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data[0] = 8'(i);
            tick();
        end
        in_valid[0] = 1'b0;
        tick();
        tick();
        chk("beat_cnt_wrap", 32'(beat_cnt[0]), 32'd1);
`endif

        idle_all();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
